// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the long-latency register scoreboard.
// Register indices are 5 bits wide, matching the architectural register file.
package reg_scoreboard_pkg;

  localparam int unsigned NREG     = 32;
  localparam int unsigned MAX_PEND = 4;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard_hazard_check.sv
// Flags one register index as blocked by an outstanding long-latency writer.
// A writeback to the same index in the current cycle bypasses the block.
module reg_scoreboard_hazard_check
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NREG = reg_scoreboard_pkg::NREG
) (
  input  logic [NREG-1:0] pending,
  input  reg_idx_t        idx,
  input  logic            used,
  input  logic            clr,
  input  reg_idx_t        wb_rd,
  output logic            hazard
);

  logic bypass;

  always_comb begin
    bypass = clr && (wb_rd == idx);
    hazard = used && (idx != REG_ZERO) && pending[idx] && !bypass;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Scoreboard of destination registers owned by in-flight long-latency writers.
// Produces the ID stall for RAW, WAW and capacity hazards and tracks the pending set.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NREG     = reg_scoreboard_pkg::NREG,
  parameter int unsigned MAX_PEND = reg_scoreboard_pkg::MAX_PEND,
  parameter int unsigned CW       = $clog2(MAX_PEND + 1)
) (
  input  logic            clk,
  input  logic            Rst,
  input  reg_idx_t        id_rs1,
  input  reg_idx_t        id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  reg_idx_t        id_rd,
  input  logic            id_regwrite,
  input  logic            id_long,
  input  logic            issue_valid,
  input  logic            flush,
  input  logic            wb_valid,
  input  reg_idx_t        wb_rd,
  output logic            stall,
  output logic [NREG-1:0] pending,
  output logic [CW-1:0]   outstanding,
  output logic            full,
  output logic            wb_err
);

  logic [NREG-1:0] pending_q, pending_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic            wb_err_q, wb_err_d;

  logic clr, iss, stray_wb;
  logic raw1, raw2, waw, structural;

  always_comb begin
    clr      = wb_valid && (wb_rd != REG_ZERO) && pending_q[wb_rd];
    stray_wb = wb_valid && (wb_rd != REG_ZERO) && !pending_q[wb_rd];
  end

  reg_scoreboard_hazard_check #(.NREG(NREG)) u_rs1_check (
    .pending (pending_q),
    .idx     (id_rs1),
    .used    (id_rs1_used),
    .clr     (clr),
    .wb_rd   (wb_rd),
    .hazard  (raw1)
  );

  reg_scoreboard_hazard_check #(.NREG(NREG)) u_rs2_check (
    .pending (pending_q),
    .idx     (id_rs2),
    .used    (id_rs2_used),
    .clr     (clr),
    .wb_rd   (wb_rd),
    .hazard  (raw2)
  );

  reg_scoreboard_hazard_check #(.NREG(NREG)) u_rd_check (
    .pending (pending_q),
    .idx     (id_rd),
    .used    (id_regwrite),
    .clr     (clr),
    .wb_rd   (wb_rd),
    .hazard  (waw)
  );

  always_comb begin
    full       = (outstanding_q == CW'(MAX_PEND));
    // A retiring writer frees its slot in time for a new issue this cycle.
    structural = id_long && id_regwrite && full && !clr;
    stall      = (raw1 || raw2 || waw || structural) && !flush;
    iss        = issue_valid && !stall && !flush && id_long && id_regwrite &&
                 (id_rd != REG_ZERO);
  end

  always_comb begin
    pending_d = pending_q;
    if (clr) pending_d[wb_rd] = 1'b0;
    // Set after clear so a same-register re-issue keeps the entry pending.
    if (iss) pending_d[id_rd] = 1'b1;
    pending_d[0] = 1'b0;

    outstanding_d = outstanding_q;
    unique case ({iss, clr})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    wb_err_d = wb_err_q || stray_wb;
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      wb_err_q      <= wb_err_d;
    end
  end

  always_comb begin
    pending     = pending_q;
    outstanding = outstanding_q;
    wb_err      = wb_err_q;
  end

  assert property (@(posedge clk) disable iff (!Rst)
    int'(outstanding_q) == $countones(pending_q));

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: load-use, capacity, WAW, x0, flush,
// stray writeback and mid-run reset, each with hand-computed expectations.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        Rst;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        id_rs1_used, id_rs2_used, id_regwrite, id_long;
  logic        issue_valid, flush, wb_valid;
  logic        stall, full, wb_err;
  logic [31:0] pending;
  logic [2:0]  outstanding;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk         (clk),
    .Rst         (Rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_long     (id_long),
    .issue_valid (issue_valid),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .stall       (stall),
    .pending     (pending),
    .outstanding (outstanding),
    .full        (full),
    .wb_err      (wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; wb_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_regwrite = 1'b0; id_long = 1'b0;
    issue_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0;
  endtask

  // Advance one cycle, then let outputs settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic long_write(input logic [4:0] rd);
    idle();
    id_rd = rd; id_regwrite = 1'b1; id_long = 1'b1; issue_valid = 1'b1;
  endtask

  task automatic writeback(input logic [4:0] rd);
    idle();
    wb_valid = 1'b1; wb_rd = rd;
  endtask

  initial begin
    idle();
    Rst = 1'b0;
    step(); step();
    Rst = 1'b1;
    #1;
    chk("reset_pending", pending, 32'h0);
    chk("reset_outstanding", 32'(outstanding), 32'd0);
    chk("reset_wb_err", 32'(wb_err), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_full", 32'(full), 32'd0);

    // Load-use on x5
    long_write(5'd5); #1;
    chk("lu_issue_stall", 32'(stall), 32'd0);
    step();
    idle(); id_rs1 = 5'd5; id_rs1_used = 1'b1; #1;
    chk("lu_pending", pending, 32'h20);
    chk("lu_outstanding", 32'(outstanding), 32'd1);
    chk("lu_stall", 32'(stall), 32'd1);
    step();
    chk("lu_stall_hold", 32'(stall), 32'd1);
    wb_valid = 1'b1; wb_rd = 5'd5; #1;
    chk("lu_bypass", 32'(stall), 32'd0);
    step();
    idle(); #1;
    chk("lu_cleared", pending, 32'h0);
    chk("lu_outstanding_0", 32'(outstanding), 32'd0);
    chk("lu_no_err", 32'(wb_err), 32'd0);

    // Capacity: fill x1..x4
    for (int i = 1; i <= 4; i++) begin
      long_write(5'(i)); step();
    end
    idle(); #1;
    chk("cap_outstanding", 32'(outstanding), 32'd4);
    chk("cap_full", 32'(full), 32'd1);
    chk("cap_pending", pending, 32'h1E);
    long_write(5'd6); #1;
    chk("cap_struct_stall", 32'(stall), 32'd1);
    wb_valid = 1'b1; wb_rd = 5'd2; #1;
    chk("cap_swap_stall", 32'(stall), 32'd0);
    step();
    idle(); #1;
    chk("cap_swap_outstanding", 32'(outstanding), 32'd4);
    chk("cap_swap_pending", pending, 32'h5A);
    chk("cap_swap_full", 32'(full), 32'd1);
    writeback(5'd1); step();
    writeback(5'd3); step();
    writeback(5'd4); step();
    writeback(5'd6); step();
    idle(); #1;
    chk("cap_drained", 32'(outstanding), 32'd0);
    chk("cap_no_err", 32'(wb_err), 32'd0);

    // WAW on x7 with and without same-cycle writeback
    long_write(5'd7); step();
    long_write(5'd7); #1;
    chk("waw_stall", 32'(stall), 32'd1);
    wb_valid = 1'b1; wb_rd = 5'd7; #1;
    chk("waw_bypass_stall", 32'(stall), 32'd0);
    step();
    idle(); #1;
    chk("waw_pending", pending, 32'h80);
    chk("waw_outstanding", 32'(outstanding), 32'd1);
    writeback(5'd7); step();

    // x0 never tracked; unused source ignored
    long_write(5'd0); step();
    idle(); #1;
    chk("x0_pending", pending, 32'h0);
    chk("x0_outstanding", 32'(outstanding), 32'd0);
    long_write(5'd9); step();
    idle(); id_rs2 = 5'd9; #1;
    chk("unused_rs2_stall", 32'(stall), 32'd0);
    id_rs2_used = 1'b1; #1;
    chk("used_rs2_stall", 32'(stall), 32'd1);
    writeback(5'd9); step();

    // Flush suppresses stall and issue; stray writeback is sticky
    long_write(5'd3); step();
    long_write(5'd10); id_rs1 = 5'd3; id_rs1_used = 1'b1; flush = 1'b1; #1;
    chk("flush_stall", 32'(stall), 32'd0);
    step();
    idle(); #1;
    chk("flush_pending", pending, 32'h8);
    chk("flush_outstanding", 32'(outstanding), 32'd1);
    writeback(5'd12); step();
    idle(); #1;
    chk("stray_wb_err", 32'(wb_err), 32'd1);
    chk("stray_pending", pending, 32'h8);
    writeback(5'd3); step();
    idle(); #1;
    chk("err_sticky", 32'(wb_err), 32'd1);
    chk("err_pending", pending, 32'h0);

    // Mid-run reset discards tracking
    long_write(5'd1); step();
    long_write(5'd2); step();
    idle(); #1;
    chk("pre_reset_pending", pending, 32'h6);
    Rst = 1'b0; step();
    Rst = 1'b1; #1;
    chk("mid_reset_pending", pending, 32'h0);
    chk("mid_reset_outstanding", 32'(outstanding), 32'd0);
    chk("mid_reset_wb_err", 32'(wb_err), 32'd0);
    writeback(5'd0); step();
    idle(); #1;
    chk("x0_wb_ignored", 32'(wb_err), 32'd0);
    writeback(5'd1); step();
    idle(); #1;
    chk("late_return_err", 32'(wb_err), 32'd1);
    chk("late_return_pending", pending, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight destination registers of long-latency instructions: loads, UART/MMIO reads and multi-cycle ops.
- These results return out of order with the pipeline. The EX_MEM/MEM_WB/WB_ID forwarding network only handles fixed-latency producers, so it cannot cover them.
- Sits beside ID. Sets a pending bit when a long-latency writer issues and clears it on late writeback.
- Drives the ID stall so no consumer reads a register before its producer completes.

Parameters:
- NREG, 32, number of architectural registers; index 0 is hardwired zero.
- MAX_PEND, 4, maximum simultaneously outstanding long-latency writers.
- CW, $clog2(MAX_PEND+1), width of outstanding counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- Rst  in  1  synchronous, active-low reset.
- id_rs1  in  5  source 1 of instruction in ID.
- id_rs2  in  5  source 2 of instruction in ID.
- id_rs1_used  in  1  instruction in ID actually reads rs1.
- id_rs2_used  in  1  instruction in ID actually reads rs2.
- id_rd  in  5  destination of instruction in ID.
- id_regwrite  in  1  instruction in ID writes rd.
- id_long  in  1  instruction in ID is a long-latency writer.
- issue_valid  in  1  pipeline wants to advance ID->EX this cycle.
- flush  in  1  ID instruction squashed this cycle (branch/trap).
- wb_valid  in  1  long-latency result written to register file this cycle.
- wb_rd  in  5  destination of that result.
- stall  out  1  hold ID and IF; insert bubble into EX.
- pending  out  NREG  pending bit per register.
- outstanding  out  CW  count of pending long writers.
- full  out  1  outstanding == MAX_PEND.
- wb_err  out  1  sticky: writeback to non-pending register.

Behaviour:
- Reset (Rst low at posedge): pending=0, outstanding=0, wb_err=0. stall and full are combinational and therefore 0 after reset. Reset mid-operation discards all tracking; in-flight returns afterwards raise wb_err.
- Effective clear: clr = wb_valid && wb_rd != 0 && pending[wb_rd].
- Hazard per source, combinational, same cycle. The source is hazardous when all of the following hold:
  - its _used bit is set;
  - the register is nonzero;
  - its pending bit is set;
  - it is not (clr && wb_rd == rs).
  Same-cycle writeback bypasses; the consumer takes wbres via forwarding.
- WAW hazard: id_regwrite && id_rd != 0 && pending[id_rd] && !(clr && wb_rd == id_rd).
- Structural hazard: id_long && id_regwrite && full && !clr.
- stall = (raw1 | raw2 | waw | structural) && !flush. A flushed instruction never stalls.
- Issue: iss = issue_valid && !stall && !flush && id_long && id_regwrite && id_rd != 0. Long writers to x0 are never tracked.
- Next-state update of pending:
  - pending[wb_rd] cleared on clr;
  - pending[id_rd] set on iss;
  - when both target the same register, set wins.
  - pending[0] is constant 0.
- outstanding: +1 on iss only, -1 on clr only, unchanged on both or neither. It never exceeds MAX_PEND and never underflows.
- wb_valid with wb_rd != 0 and !pending[wb_rd] sets wb_err, with no other state change. wb_rd == 0 is silently ignored.
- Invariant, assertable: outstanding == popcount(pending).
- Latency: pending visible one cycle after issue; stall is zero-latency combinational from ID inputs and current state.

Decomposition:
- Shared package: NREG, MAX_PEND, the reg_idx_t (logic [4:0]) typedef and the REG_ZERO constant.
- One natural sub-module, hazard_check: pure combinational comparison of one source index against pending plus the bypass. It is instantiated three times (rs1, rs2, rd).
- Counter and pending array stay in reg_scoreboard.

Test Plan:
- Load-use: issue long write x5, then ID reads rs1=x5 -> stall=1 until wb_valid wb_rd=5. In the wb cycle stall=0 (bypass); next cycle pending[5]=0 and outstanding=0.
- Capacity: issue long writes x1..x4 in consecutive cycles -> outstanding=4 and full=1. A fifth long write x6 -> stall=1. Same cycle wb_rd=2 -> stall=0; outstanding stays 4 with pending={1,3,4,6}.
- WAW with same-cycle set/clear: x7 pending, ID long write to x7 with wb_rd=7 in the same cycle -> no stall, pending[7] remains 1, outstanding unchanged.
- x0 and unused sources: long write to x0 -> pending=0 and outstanding=0. With x9 pending, ID rs2=x9 and id_rs2_used=0 -> stall=0.
- Flush/error: x3 pending, ID reads x3 with flush=1 -> stall=0 and nothing set. wb_valid wb_rd=12 while not pending -> wb_err=1, remaining set after later valid traffic.
- Reset mid-operation: two pending entries, Rst=0 for one cycle -> pending=0, outstanding=0, wb_err=0. A following wb_rd of an old entry -> wb_err=1.
